// File: rtl/adder_axi_master_if.sv
// adder_axi_master_if: AXI4-Lite bus between the adder sequencer and its slave, with 1-bit responses
interface adder_axi_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/adder_axi_master.sv
// adder_axi_master: writes an operand pair to the adder slave over AXI4-Lite and reads the sum back
module adder_axi_master #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDR_WIDTH     = 8,
    parameter logic [ADDR_WIDTH-1:0] OPA_ADDR       = 'h0,
    parameter logic [ADDR_WIDTH-1:0] OPB_ADDR       = 'h4,
    parameter logic [ADDR_WIDTH-1:0] RES_ADDR       = 'h8,
    parameter int                    TIMEOUT_CYCLES = 255
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_sum,
    output logic                  res_err,
    output logic                  res_timeout,
    adder_axi_master_if.master    m1_axi
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] WR_A      = 3'd1;
    localparam logic [2:0] WR_A_RESP = 3'd2;
    localparam logic [2:0] WR_B      = 3'd3;
    localparam logic [2:0] WR_B_RESP = 3'd4;
    localparam logic [2:0] RD_ADDR   = 3'd5;
    localparam logic [2:0] RD_DATA   = 3'd6;
    localparam logic [2:0] DONE      = 3'd7;
    localparam logic [7:0] TMAX      = 8'(TIMEOUT_CYCLES - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] opb;
    logic [7:0]            tcnt;
    logic                  aw_done, w_done;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                  wr_state, wr_fin, busy, advance, expire;

    assign m1_axi.wstrb = '1;

    always_comb begin
        aw_hs    = m1_axi.awvalid & m1_axi.awready;
        w_hs     = m1_axi.wvalid & m1_axi.wready;
        b_hs     = m1_axi.bvalid & m1_axi.bready;
        ar_hs    = m1_axi.arvalid & m1_axi.arready;
        r_hs     = m1_axi.rvalid & m1_axi.rready;
        wr_state = state == WR_A || state == WR_B;
        wr_fin   = wr_state && (aw_done || aw_hs) && (w_done || w_hs);
        busy     = state != IDLE && state != DONE;
        advance  = wr_fin || b_hs || ar_hs || r_hs;
        // a handshake landing on the last allowed cycle still wins over the abort
        expire   = busy && !advance && tcnt == TMAX;
    end

    always_ff @(posedge m1_axi_aclk or negedge m1_axi_aresetn) begin
        if (!m1_axi_aresetn) begin
            state          <= IDLE;
            opb            <= '0;
            tcnt           <= '0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            cmd_ready      <= 1'b1;
            res_valid      <= 1'b0;
            res_sum        <= '0;
            res_err        <= 1'b0;
            res_timeout    <= 1'b0;
            m1_axi.awaddr  <= '0;
            m1_axi.awvalid <= 1'b0;
            m1_axi.wdata   <= '0;
            m1_axi.wvalid  <= 1'b0;
            m1_axi.bready  <= 1'b0;
            m1_axi.araddr  <= '0;
            m1_axi.arvalid <= 1'b0;
            m1_axi.rready  <= 1'b0;
        end else begin
            tcnt <= (advance || !busy) ? '0 : tcnt + 1'b1;
            if (expire) begin
                state          <= DONE;
                aw_done        <= 1'b0;
                w_done         <= 1'b0;
                m1_axi.awvalid <= 1'b0;
                m1_axi.wvalid  <= 1'b0;
                m1_axi.bready  <= 1'b0;
                m1_axi.arvalid <= 1'b0;
                m1_axi.rready  <= 1'b0;
                res_sum        <= '0;
                res_timeout    <= 1'b1;
                res_valid      <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (cmd_valid && cmd_ready) begin
                        state          <= WR_A;
                        cmd_ready      <= 1'b0;
                        opb            <= cmd_b;
                        res_err        <= 1'b0;
                        res_timeout    <= 1'b0;
                        m1_axi.awaddr  <= OPA_ADDR;
                        m1_axi.wdata   <= cmd_a;
                        m1_axi.awvalid <= 1'b1;
                        m1_axi.wvalid  <= 1'b1;
                    end
                    WR_A, WR_B: begin
                        if (aw_hs) m1_axi.awvalid <= 1'b0;
                        if (w_hs) m1_axi.wvalid <= 1'b0;
                        aw_done <= !wr_fin && (aw_done || aw_hs);
                        w_done  <= !wr_fin && (w_done || w_hs);
                        if (wr_fin) begin
                            state         <= state == WR_A ? WR_A_RESP : WR_B_RESP;
                            m1_axi.bready <= 1'b1;
                        end
                    end
                    WR_A_RESP, WR_B_RESP: if (b_hs) begin
                        res_err       <= res_err | m1_axi.bresp;
                        m1_axi.bready <= 1'b0;
                        if (state == WR_A_RESP) begin
                            state          <= WR_B;
                            m1_axi.awaddr  <= OPB_ADDR;
                            m1_axi.wdata   <= opb;
                            m1_axi.awvalid <= 1'b1;
                            m1_axi.wvalid  <= 1'b1;
                        end else begin
                            state          <= RD_ADDR;
                            m1_axi.araddr  <= RES_ADDR;
                            m1_axi.arvalid <= 1'b1;
                        end
                    end
                    RD_ADDR: if (ar_hs) begin
                        state          <= RD_DATA;
                        m1_axi.arvalid <= 1'b0;
                        m1_axi.rready  <= 1'b1;
                    end
                    RD_DATA: if (r_hs) begin
                        state         <= DONE;
                        res_sum       <= m1_axi.rdata;
                        res_err       <= res_err | m1_axi.rresp;
                        m1_axi.rready <= 1'b0;
                        res_valid     <= 1'b1;
                    end
                    DONE: if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adder_axi_master.sv
// tb_adder_axi_master: adder-slave model, vector table and scoreboard for adder_axi_master
module tb_adder_axi_master;
    localparam int DW = 32;
    localparam int AW = 8;

    typedef struct packed { logic [DW-1:0] sum; logic err; logic to; } res_t;
    typedef struct { logic [DW-1:0] a, b, sum; int aw_d, w_d; logic ba, bb, rr, err; } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          cmd_valid = 1'b0, res_ready = 1'b1;
    logic [DW-1:0] cmd_a = '0, cmd_b = '0;
    logic          cmd_ready, res_valid, res_err, res_timeout;
    logic [DW-1:0] res_sum;

    adder_axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

    adder_axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m1_axi_aclk(clk), .m1_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_err(res_err), .res_timeout(res_timeout), .m1_axi(m1_axi)
    );

    always #5 clk = ~clk;

    // adder slave: per-channel ready delays, configurable responses, returns opa+opb
    int            aw_dly = 0, w_dly = 0, aw_cnt, w_cnt;
    logic          ar_hang = 1'b0, bresp_a = 1'b0, bresp_b = 1'b0, rresp_cfg = 1'b0;
    logic          aw_got, w_got, aw_hs, w_hs, ar_hs;
    logic [AW-1:0] aw_l, a_now;
    logic [DW-1:0] w_l, d_now, opa_r, opb_r;

    assign m1_axi.awready = m1_axi.awvalid && aw_cnt >= aw_dly;
    assign m1_axi.wready  = m1_axi.wvalid && w_cnt >= w_dly;
    assign m1_axi.arready = m1_axi.arvalid && !ar_hang;
    assign aw_hs = m1_axi.awvalid && m1_axi.awready;
    assign w_hs  = m1_axi.wvalid && m1_axi.wready;
    assign ar_hs = m1_axi.arvalid && m1_axi.arready;
    assign a_now = aw_hs ? m1_axi.awaddr : aw_l;
    assign d_now = w_hs ? m1_axi.wdata : w_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            aw_l <= '0; w_l <= '0; opa_r <= '0; opb_r <= '0;
            m1_axi.bvalid <= 1'b0; m1_axi.bresp <= 1'b0;
            m1_axi.rvalid <= 1'b0; m1_axi.rresp <= 1'b0; m1_axi.rdata <= '0;
        end else begin
            aw_cnt <= (m1_axi.awvalid && !m1_axi.awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m1_axi.wvalid && !m1_axi.wready) ? w_cnt + 1 : 0;
            if (m1_axi.bvalid && m1_axi.bready) m1_axi.bvalid <= 1'b0;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                if (a_now == 8'h00) opa_r <= d_now;
                else if (a_now == 8'h04) opb_r <= d_now;
                m1_axi.bvalid <= 1'b1;
                m1_axi.bresp  <= a_now == 8'h04 ? bresp_b : bresp_a;
            end else begin
                if (aw_hs) begin aw_got <= 1'b1; aw_l <= m1_axi.awaddr; end
                if (w_hs) begin w_got <= 1'b1; w_l <= m1_axi.wdata; end
            end
            if (ar_hs) begin
                m1_axi.rvalid <= 1'b1;
                m1_axi.rdata  <= opa_r + opb_r;
                m1_axi.rresp  <= rresp_cfg;
            end else if (m1_axi.rvalid && m1_axi.rready) m1_axi.rvalid <= 1'b0;
        end
    end

    logic [AW-1:0] exp_aw[$];
    logic [DW-1:0] exp_w[$];
    res_t          exp_res[$];
    int            errors = 0, checks = 0;
    logic          rv_seen = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: every AXI handshake and result is matched against what the stimulus queued
    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid) rv_seen = 1'b1;
            if (aw_hs) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", {1'b1, m1_axi.awaddr}, 0);
                else chk("awaddr", m1_axi.awaddr, exp_aw.pop_front());
            end
            if (w_hs) begin
                if (exp_w.size() == 0) chk("w_unexpected", {1'b1, m1_axi.wdata}, 0);
                else chk("wdata", {m1_axi.wstrb, m1_axi.wdata}, {4'hF, exp_w.pop_front()});
            end
            if (ar_hs) chk("araddr", m1_axi.araddr, 8'h08);
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) chk("res_unexpected", {1'b1, res_sum}, 0);
                else chk("result", {res_sum, res_err, res_timeout}, exp_res.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input res_t r);
        int n = 0;
        while (!cmd_ready && n < 50) begin step(); n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        exp_aw.push_back(8'h00); exp_aw.push_back(8'h04);
        exp_w.push_back(a); exp_w.push_back(b);
        exp_res.push_back(r);
        cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 600) begin step(); lat++; end
        chk("res_valid_wait", res_valid, 1);
        step();
    endtask

    vec_t vecs[6];

    initial begin
        int lat, n;
        vecs[0] = '{a: 23, b: 30, sum: 53, aw_d: 0, w_d: 0, ba: 0, bb: 0, rr: 0, err: 0};
        vecs[1] = '{a: 40, b: 60, sum: 100, aw_d: 0, w_d: 0, ba: 0, bb: 1, rr: 0, err: 1};
        vecs[2] = '{a: 32'hFFFF_FFFF, b: 1, sum: 0, aw_d: 2, w_d: 1, ba: 0, bb: 0, rr: 0, err: 0};
        vecs[3] = '{a: 32'h1234_5678, b: 32'h1111_1111, sum: 32'h2345_6789, aw_d: 1, w_d: 1, ba: 0, bb: 0, rr: 1, err: 1};
        vecs[4] = '{a: 32'h7FFF_FFFF, b: 32'h8000_0000, sum: 32'hFFFF_FFFF, aw_d: 0, w_d: 2, ba: 1, bb: 0, rr: 0, err: 1};
        vecs[5] = '{a: 0, b: 0, sum: 0, aw_d: 4, w_d: 0, ba: 0, bb: 0, rr: 0, err: 0};

        step(); step();
        chk("reset_ctrl", {cmd_ready, res_valid, m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready,
                           m1_axi.arvalid, m1_axi.rready, res_err, res_timeout}, 9'b1_0000_0000);
        chk("reset_data", {m1_axi.awaddr, m1_axi.araddr, m1_axi.wdata, res_sum, m1_axi.wstrb},
                          {8'h0, 8'h0, 32'h0, 32'h0, 4'hF});
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            aw_dly = vecs[i].aw_d; w_dly = vecs[i].w_d;
            bresp_a = vecs[i].ba; bresp_b = vecs[i].bb; rresp_cfg = vecs[i].rr;
            send(vecs[i].a, vecs[i].b, '{vecs[i].sum, vecs[i].err, 1'b0});
            wait_res(lat);
            if (vecs[i].aw_d == 0 && vecs[i].w_d == 0) chk("latency", lat, 6);
            chk("sb_drained", exp_aw.size() + exp_w.size() + exp_res.size(), 0);
        end
        bresp_a = 1'b0; bresp_b = 1'b0; rresp_cfg = 1'b0;

        // skewed WR_A: address accepted at once, data held three extra cycles
        aw_dly = 0; w_dly = 3;
        send(23, 30, '{32'd53, 1'b0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            step();
            chk("skew_hold", {m1_axi.awvalid, m1_axi.wvalid, m1_axi.wdata}, {1'b0, 1'b1, 32'd23});
        end
        wait_res(lat);
        w_dly = 0;

        // read address never accepted
        ar_hang = 1'b1;
        send(1, 2, '{32'd0, 1'b0, 1'b1});
        n = 0;
        while (!m1_axi.arvalid && n < 50) begin step(); n++; end
        chk("arvalid_wait", m1_axi.arvalid, 1);
        n = 0;
        while (m1_axi.arvalid && n < 400) begin step(); n++; end
        chk("timeout_cycles", n, 255);
        chk("timeout_state", {m1_axi.arvalid, res_valid, res_timeout}, 3'b011);
        wait_res(lat);
        ar_hang = 1'b0;

        // result backpressure with the next command already waiting
        res_ready = 1'b0;
        send(5, 6, '{32'd11, 1'b0, 1'b0});
        n = 0;
        while (!res_valid && n < 100) begin step(); n++; end
        chk("bp_valid_wait", res_valid, 1);
        exp_aw.push_back(8'h00); exp_aw.push_back(8'h04);
        exp_w.push_back(1); exp_w.push_back(2);
        exp_res.push_back('{32'd3, 1'b0, 1'b0});
        cmd_a = 1; cmd_b = 2; cmd_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold", {res_valid, cmd_ready, res_sum}, {1'b1, 1'b0, 32'd11});
        end
        res_ready = 1'b1;
        step();
        chk("bp_release", {res_valid, cmd_ready}, 2'b01);
        step();
        chk("bp_accept", cmd_ready, 0);
        cmd_valid = 1'b0;
        wait_res(lat);

        // reset while operand B is being written
        w_dly = 6;
        send(9, 8, '{32'd17, 1'b0, 1'b0});
        n = 0;
        while (!(m1_axi.awvalid && m1_axi.awaddr == 8'h04) && n < 50) begin step(); n++; end
        chk("wr_b_reach", {m1_axi.awvalid, m1_axi.wvalid, m1_axi.awaddr}, {1'b1, 1'b1, 8'h04});
        rst_n = 1'b0;
        #1;
        chk("reset_async", {m1_axi.awvalid, m1_axi.wvalid, m1_axi.bready, cmd_ready, res_valid}, 5'b00010);
        exp_aw.delete(); exp_w.delete(); exp_res.delete();
        rv_seen = 1'b0;
        w_dly = 0;
        step(); step();
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", cmd_ready, 1);
        for (int k = 0; k < 20; k++) step();
        chk("no_result_after_rst", rv_seen, 0);

        send(2, 3, '{32'd5, 1'b0, 1'b0});
        wait_res(lat);
        chk("latency_after_rst", lat, 6);
        chk("sb_final", exp_aw.size() + exp_w.size() + exp_res.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
